// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: synchronizes and de-glitches the PS/2 lines,
// deframes 11-bit frames and shifts each good byte into a two-byte history.
module ps2_rx_frontend #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KBBuffer,
    output logic        Byte_Valid,
    output logic        Parity_Err,
    output logic        Frame_Err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]            clk_sync, dat_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk, filt_dly, fall, sdat;
    state_t                state_q, state_d;
    logic [2:0]            bit_cnt;
    logic [7:0]            sh_byte;
    logic                  par_ok;
    logic [TW-1:0]         to_cnt;
    logic                  timeout;
    logic                  bv_d, pe_d, fe_d, kb_we;

    assign sdat    = dat_sync[1];
    // One-cycle strobe: filtered clock was high last cycle and is low now.
    assign fall    = filt_dly & ~filt_clk;
    assign timeout = (state_q != IDLE) && (to_cnt == TO_MAX);

    // Two-flop synchronizers; idle-high lines reset to 1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
        end
    end

    // Glitch filter: level only flips after FILTER_LEN identical samples.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            filt_sr  <= '1;
            filt_clk <= 1'b1;
            filt_dly <= 1'b1;
        end else begin
            filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
            filt_dly <= filt_clk;
            if (&filt_sr)
                filt_clk <= 1'b1;
            else if (~|filt_sr)
                filt_clk <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: advances on falling edges; timeout abandons the frame.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    state_d = sdat ? IDLE : DATA;
                DATA:    state_d = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: next values of the registered result pulses.
    always_comb begin
        bv_d  = 1'b0;
        pe_d  = 1'b0;
        fe_d  = 1'b0;
        kb_we = 1'b0;
        if (timeout) begin
            fe_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: fe_d = sdat;
                STOP: begin
                    kb_we = sdat & par_ok;
                    bv_d  = sdat & par_ok;
                    pe_d  = ~par_ok;
                    fe_d  = ~sdat;
                end
                default: ;
            endcase
        end
    end

    // Frame datapath: bit counter, LSB-first shift byte, parity latch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt <= '0;
            sh_byte <= '0;
            par_ok  <= 1'b0;
        end else if (fall && !timeout) begin
            case (state_q)
                IDLE:   bit_cnt <= '0;
                DATA: begin
                    sh_byte[bit_cnt] <= sdat;
                    bit_cnt          <= bit_cnt + 3'd1;
                end
                PARITY: par_ok <= (^sh_byte) ^ sdat;
                default: ;
            endcase
        end
    end

    // Inactivity counter: cleared on edges and in IDLE, saturating otherwise.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            to_cnt <= '0;
        else if (fall || state_q == IDLE)
            to_cnt <= '0;
        else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;
    end

    // Registered outputs; history shifts only on a fully good frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            KBBuffer   <= '0;
            Byte_Valid <= 1'b0;
            Parity_Err <= 1'b0;
            Frame_Err  <= 1'b0;
        end else begin
            Byte_Valid <= bv_d;
            Parity_Err <= pe_d;
            Frame_Err  <= fe_d;
            if (kb_we)
                KBBuffer <= {KBBuffer[7:0], sh_byte};
        end
    end
endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Scoreboard bench for ps2_rx_frontend: a frame-level model pushes expected
// result events; a monitor pops and compares whenever the DUT reports.
module tb_ps2_rx_frontend;
    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 40;   // PS/2 half period in CLK cycles (time-scaled)

    logic        CLK = 1'b0, RESET = 1'b1, PS2_CLK = 1'b1, PS2_DATA = 1'b1;
    logic [15:0] KBBuffer;
    logic        Byte_Valid, Parity_Err, Frame_Err;

    typedef struct {
        logic        bv, pe, fe;
        logic [15:0] kb;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] model_kb = 16'h0000;
    logic [15:0] prev_kb  = 16'h0000;
    int          checks = 0, failures = 0;
    int          cyc = 0, last_fe_cyc = -1, fall_cyc = 0;

    ps2_rx_frontend #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .KBBuffer(KBBuffer), .Byte_Valid(Byte_Valid),
        .Parity_Err(Parity_Err), .Frame_Err(Frame_Err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Monitor: every reported event must match the head of the queue, and
    // KBBuffer must never change without a Byte_Valid pulse.
    always @(negedge CLK) begin
        ev_t e;
        if (RESET) begin
            prev_kb = KBBuffer;
        end else begin
            if (Byte_Valid || Parity_Err || Frame_Err) begin
                if (Frame_Err) last_fe_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got bv=%0b pe=%0b fe=%0b kb=%h, none expected",
                             Byte_Valid, Parity_Err, Frame_Err, KBBuffer);
                end else begin
                    e = exp_q.pop_front();
                    if (e.bv !== Byte_Valid || e.pe !== Parity_Err ||
                        e.fe !== Frame_Err || e.kb !== KBBuffer) begin
                        failures++;
                        $display("FAIL event got bv=%0b pe=%0b fe=%0b kb=%h want bv=%0b pe=%0b fe=%0b kb=%h",
                                 Byte_Valid, Parity_Err, Frame_Err, KBBuffer,
                                 e.bv, e.pe, e.fe, e.kb);
                    end
                end
            end else if (KBBuffer !== prev_kb) begin
                checks++;
                failures++;
                $display("FAIL kb_change_without_valid got %h was %h", KBBuffer, prev_kb);
            end
            prev_kb = KBBuffer;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
    endtask

    // One PS/2 bit: device sets data while clock high, host samples on fall.
    // A glitch puts a short low pulse on PS2_CLK in the middle of the high phase.
    task automatic send_bit(input logic b, input bit glitch);
        PS2_DATA = b;
        if (glitch) begin
            wait_cyc(HALF / 2);
            PS2_CLK = 1'b0;
            wait_cyc(FL - 2);
            PS2_CLK = 1'b1;
            wait_cyc(HALF - HALF / 2 - (FL - 2));
        end else begin
            wait_cyc(HALF);
        end
        PS2_CLK  = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Full frame plus the outcome the frame rules predict.
    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input bit glitch);
        logic [10:0] bits;
        ev_t         e;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        if (!bad_par && !bad_stop) begin
            model_kb = {model_kb[7:0], d};
            e = '{bv: 1'b1, pe: 1'b0, fe: 1'b0, kb: model_kb};
        end else begin
            e = '{bv: 1'b0, pe: bad_par, fe: bad_stop, kb: model_kb};
        end
        exp_q.push_back(e);
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
        PS2_DATA = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    // Start bit plus nbits data bits, then lines left idle.
    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i], 1'b0);
        PS2_DATA = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        ev_t e;
        int  dly;
        wait_cyc(5);
        #1;
        chk("reset_kb", 32'(KBBuffer), 32'h0);
        chk("reset_pulses", {29'd0, Byte_Valid, Parity_Err, Frame_Err}, 32'h0);
        RESET = 1'b0;
        wait_cyc(20);

        // Basic frame and a make/break sequence.
        send_frame(8'h1C, 0, 0, 0);
        chk("kb_after_1C", 32'(KBBuffer), 32'h001C);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        chk("kb_after_seq", 32'(KBBuffer), 32'hF01C);

        // Parity error, then recovery.
        send_frame(8'h45, 1, 0, 0);
        chk("kb_hold_par", 32'(KBBuffer), 32'hF01C);
        send_frame(8'h16, 0, 0, 0);
        chk("kb_after_16", 32'(KBBuffer), 32'h1C16);

        // Bad stop bit; then a lone falling edge with data high (bad start).
        send_frame(8'h29, 0, 1, 0);
        chk("kb_hold_stop", 32'(KBBuffer), 32'h1C16);
        e = '{bv: 1'b0, pe: 1'b0, fe: 1'b1, kb: model_kb};
        exp_q.push_back(e);
        send_bit(1'b1, 1'b0);
        wait_cyc(3 * HALF);

        // Timeout: Frame_Err about TO cycles after the last falling edge.
        e = '{bv: 1'b0, pe: 1'b0, fe: 1'b1, kb: model_kb};
        exp_q.push_back(e);
        last_fe_cyc = -1;
        send_partial(8'hA7, 4);
        for (int i = 0; i < TO + 200 && last_fe_cyc < 0; i++) wait_cyc(1);
        dly = (last_fe_cyc < 0) ? -1 : last_fe_cyc - fall_cyc;
        checks++;
        if (dly < TO + FL || dly > TO + FL + 10) begin
            failures++;
            $display("FAIL timeout_delay got %0d want %0d..%0d", dly, TO + FL, TO + FL + 10);
        end
        wait_cyc(20);
        send_frame(8'h5A, 0, 0, 0);
        chk("kb_after_5A", 32'(KBBuffer[7:0]), 32'h5A);

        // Sub-filter-length glitches between bits.
        send_frame(8'h76, 0, 0, 1);
        chk("kb_after_glitch", 32'(KBBuffer), 32'h5A76);

        // Reset mid-frame.
        send_partial(8'h3B, 5);
        wait_cyc(2);
        RESET = 1'b1;
        model_kb = 16'h0000;
        wait_cyc(3);
        #1;
        chk("midreset_kb", 32'(KBBuffer), 32'h0);
        chk("midreset_pulses", {29'd0, Byte_Valid, Parity_Err, Frame_Err}, 32'h0);
        chk("midreset_queue", 32'(exp_q.size()), 32'h0);
        RESET = 1'b0;
        wait_cyc(3 * HALF);
        send_frame(8'h05, 0, 0, 0);
        chk("kb_after_05", 32'(KBBuffer), 32'h0005);

        // Randomized frames: mostly good, some with parity/stop faults.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            int         r;
            d = 8'($urandom);
            r = $urandom_range(0, 9);
            send_frame(d, r == 7 || r == 9, r == 8 || r == 9, r == 6);
        end
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        chk("kb_repeat", 32'(KBBuffer), 32'hE0E0);

        // Drain: every expected event must have been reported.
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_cyc(1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
